control_unit: RTL and testbench

//  Control-unit FSM directly upstream of DataPath: consumes IR75 opcode and Aeq0/Apos status,

---
 rtl/cu_pkg.sv | 35 +++
 rtl/control_unit_step_edge.sv | 28 ++
 rtl/control_unit.sv | 154 +++++++++++++++
 tb/tb_control_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared constants for the control unit: FSM state codes, opcodes and
// A-source select codes. Execute states are {1'b1, opcode}.
package cu_pkg;

    localparam logic [3:0] ST_START  = 4'b0000;
    localparam logic [3:0] ST_FETCH  = 4'b0001;
    localparam logic [3:0] ST_DECODE = 4'b0010;
    localparam logic [3:0] ST_WAIT   = 4'b0011;  // single-step hold before FETCH
    localparam logic [3:0] ST_LOAD   = 4'b1000;
    localparam logic [3:0] ST_STORE  = 4'b1001;
    localparam logic [3:0] ST_ADD    = 4'b1010;
    localparam logic [3:0] ST_SUB    = 4'b1011;
    localparam logic [3:0] ST_INPUT  = 4'b1100;
    localparam logic [3:0] ST_JZ     = 4'b1101;
    localparam logic [3:0] ST_JPOS   = 4'b1110;
    localparam logic [3:0] ST_HALT   = 4'b1111;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam logic [1:0] ASEL_ALU = 2'd0;
    localparam logic [1:0] ASEL_IN  = 2'd1;
    localparam logic [1:0] ASEL_RAM = 2'd2;

    function automatic logic [3:0] exec_state(input logic [2:0] op);
        return {1'b1, op};
    endfunction

endpackage

// File: rtl/control_unit_step_edge.sv
// Single-step helper: registers the operator step input and produces a
// one-cycle pulse on its rising edge. Only built with CU_SINGLE_STEP_EN.
`ifdef CU_SINGLE_STEP_EN
module step_edge (
    input  logic clk,
    input  logic clear,
    input  logic step,
    output logic step_pulse
);

    logic step_q;
    logic step_d;

    // Next value of the step history register
    always_comb begin
        step_d = step;
    end

    // Step history register, cleared asynchronously
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) step_q <= 1'b0;
        else        step_q <= step_d;
    end

    assign step_pulse = step & ~step_q;

endmodule
`endif

// File: rtl/control_unit.sv
// Control-unit FSM driving the DataPath: fetch -> decode -> execute per
// instruction, INPUT waits on enter, HALT is absorbing until clear.
// Optional feature macro CU_SINGLE_STEP_EN adds a `step` port and holds
// every entry into FETCH until a rising edge of step is seen.
module control_unit
    import cu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [2:0]       IR75,
    input  logic             Aeq0,
    input  logic             Apos,
    input  logic             enter,
`ifdef CU_SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             IRload,
    output logic             JMPmux,
    output logic             PCload,
    output logic             Meminst,
    output logic             MemWr,
    output logic [1:0]       Asel,
    output logic             Aload,
    output logic             Sub,
    output logic             halt,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_count
);

`ifdef CU_SINGLE_STEP_EN
    localparam logic [3:0] FETCH_ENTRY = ST_WAIT;
    logic step_pulse;

    step_edge u_step_edge (
        .clk        (clk),
        .clear      (clear),
        .step       (step),
        .step_pulse (step_pulse)
    );
`else
    localparam logic [3:0] FETCH_ENTRY = ST_FETCH;
`endif

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    // Next-state and retirement decision; HALT entry retires from DECODE
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            ST_START:  state_d = FETCH_ENTRY;
`ifdef CU_SINGLE_STEP_EN
            ST_WAIT:   if (step_pulse) state_d = ST_FETCH;
`endif
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                state_d = exec_state(IR75);
                retire  = (IR75 == OP_HALT);
            end
            ST_INPUT: begin
                if (enter) begin
                    state_d = FETCH_ENTRY;
                    retire  = 1'b1;
                end
            end
            ST_HALT:   state_d = ST_HALT;
            default: begin
                if (state_q[3]) begin
                    state_d = FETCH_ENTRY;
                    retire  = 1'b1;
                end else begin
                    state_d = ST_START;
                end
            end
        endcase
    end

    // Retired-instruction counter, wraps modulo 2^CNT_W
    always_comb begin
        cnt_d = cnt_q;
        if (retire) cnt_d = cnt_q + CNT_W'(1);
    end

    // State and counter registers, cleared asynchronously
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= ST_START;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output decode: Moore from state, except Aload/PCload which follow inputs
    always_comb begin
        IRload  = 1'b0;
        JMPmux  = 1'b0;
        PCload  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Asel    = ASEL_ALU;
        Aload   = 1'b0;
        Sub     = 1'b0;
        halt    = 1'b0;
        case (state_q)
            ST_FETCH: begin
                IRload = 1'b1;
                PCload = 1'b1;
            end
            ST_DECODE: Meminst = 1'b1;
            ST_LOAD: begin
                Meminst = 1'b1;
                Asel    = ASEL_RAM;
                Aload   = 1'b1;
            end
            ST_STORE: begin
                Meminst = 1'b1;
                MemWr   = 1'b1;
            end
            ST_ADD: begin
                Meminst = 1'b1;
                Aload   = 1'b1;
            end
            ST_SUB: begin
                Meminst = 1'b1;
                Aload   = 1'b1;
                Sub     = 1'b1;
            end
            ST_INPUT: begin
                Asel  = ASEL_IN;
                Aload = enter;
            end
            ST_JZ: begin
                JMPmux = 1'b1;
                PCload = Aeq0;
            end
            ST_JPOS: begin
                JMPmux = 1'b1;
                PCload = Apos;
            end
            ST_HALT: halt = 1'b1;
            default: ;
        endcase
    end

    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// Randomised scoreboard bench for control_unit: the stimulus side expands each
// instruction into its expected per-cycle control vectors from the instruction
// semantics and queues them; a negedge monitor pops and compares.
module tb_control_unit;
    import cu_pkg::*;

    localparam int unsigned CNT_W = 3;

    logic clk = 1'b0;
    logic clear, Aeq0, Apos, enter;
    logic [2:0] IR75;
`ifdef CU_SINGLE_STEP_EN
    logic step = 1'b0;
`endif
    logic IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, halt;
    logic [1:0] Asel;
    logic [3:0] state;
    logic [CNT_W-1:0] instr_count;

    control_unit #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .clear       (clear),
        .IR75        (IR75),
        .Aeq0        (Aeq0),
        .Apos        (Apos),
        .enter       (enter),
`ifdef CU_SINGLE_STEP_EN
        .step        (step),
`endif
        .IRload      (IRload),
        .JMPmux      (JMPmux),
        .PCload      (PCload),
        .Meminst     (Meminst),
        .MemWr       (MemWr),
        .Asel        (Asel),
        .Aload       (Aload),
        .Sub         (Sub),
        .halt        (halt),
        .state       (state),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       st;
        logic             irload, jmpmux, pcload, meminst, memwr;
        logic [1:0]       asel;
        logic             aload, sub, hlt;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned model_cnt = 0;

    function automatic obs_t sample();
        obs_t o;
        o.st = state; o.irload = IRload; o.jmpmux = JMPmux; o.pcload = PCload;
        o.meminst = Meminst; o.memwr = MemWr; o.asel = Asel; o.aload = Aload;
        o.sub = Sub; o.hlt = halt; o.cnt = instr_count;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("st=%b ir=%b jm=%b pc=%b mi=%b mw=%b as=%0d al=%b sb=%b h=%b n=%0d",
                         o.st, o.irload, o.jmpmux, o.pcload, o.meminst, o.memwr,
                         o.asel, o.aload, o.sub, o.hlt, o.cnt);
    endfunction

    function automatic void check(string nm, obs_t act, obs_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {%s} expected {%s}", nm, fmt(act), fmt(exp));
        end
    endfunction

    function automatic obs_t blank();
        obs_t e = '0;
        e.cnt = CNT_W'(model_cnt);
        return e;
    endfunction

    // Monitor: compare every queued expectation against the DUT mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() != 0) check(name_q.pop_front(), sample(), exp_q.pop_front());
    end

    // Queue one cycle's expectation, then move to just after the next edge
    task automatic cyc(input obs_t e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        IR75  = 3'($urandom);
        Aeq0  = 1'($urandom);
        Apos  = 1'($urandom);
        enter = 1'($urandom);
    endtask

    task automatic retire_one();
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
    endtask

    // One instruction, expanded from its meaning into per-cycle expectations
    task automatic run_instr(input logic [2:0] op, input int unsigned wait_n,
                             input logic a0, input logic ap, input bit abort);
        obs_t e;
`ifdef CU_SINGLE_STEP_EN
        for (int i = 0; i < 2; i++) begin
            rand_inputs(); step = 1'b0;
            e = blank(); e.st = ST_WAIT; cyc(e, "step_wait");
        end
        rand_inputs(); step = 1'b1;
        e = blank(); e.st = ST_WAIT; cyc(e, "step_edge");
        step = 1'b0;
`endif
        rand_inputs();
        e = blank(); e.st = ST_FETCH; e.irload = 1'b1; e.pcload = 1'b1;
        cyc(e, "fetch");

        rand_inputs(); IR75 = op;
        e = blank(); e.st = ST_DECODE; e.meminst = 1'b1;
        cyc(e, "decode");

        rand_inputs();
        e = blank(); e.st = {1'b1, op};
        case (op)
            OP_LOAD: begin
                e.meminst = 1'b1; e.asel = 2'd2; e.aload = 1'b1;
                cyc(e, "load"); retire_one();
            end
            OP_STORE: begin
                if (abort) begin
                    #1;
                    e.memwr = 1'b1; e.meminst = 1'b1;
                    check("store_before_clear", sample(), e);
                    clear = 1'b0;
                    #1;
                    model_cnt = 0;
                    check("store_async_clear", sample(), blank());
                end else begin
                    e.meminst = 1'b1; e.memwr = 1'b1;
                    cyc(e, "store"); retire_one();
                end
            end
            OP_ADD: begin
                e.meminst = 1'b1; e.aload = 1'b1;
                cyc(e, "add"); retire_one();
            end
            OP_SUB: begin
                e.meminst = 1'b1; e.aload = 1'b1; e.sub = 1'b1;
                cyc(e, "sub"); retire_one();
            end
            OP_INPUT: begin
                e.asel = 2'd1;
                for (int unsigned i = 0; i < wait_n; i++) begin
                    enter = 1'b0; e.aload = 1'b0;
                    cyc(e, "input_wait");
                    rand_inputs();
                end
                enter = 1'b1; e.aload = 1'b1;
                cyc(e, "input_enter"); retire_one();
            end
            OP_JZ: begin
                Aeq0 = a0; e.jmpmux = 1'b1; e.pcload = a0;
                cyc(e, "jz"); retire_one();
            end
            OP_JPOS: begin
                Apos = ap; e.jmpmux = 1'b1; e.pcload = ap;
                cyc(e, "jpos"); retire_one();
            end
            default: begin
                retire_one();
                for (int i = 0; i < 10; i++) begin
                    rand_inputs();
                    e = blank(); e.st = ST_HALT; e.hlt = 1'b1;
                    cyc(e, "halt");
                end
            end
        endcase
    endtask

    task automatic do_reset();
        clear = 1'b0;
        rand_inputs();
        repeat (2) @(posedge clk);
        #1;
        model_cnt = 0;
        check("reset_state", sample(), blank());
        clear = 1'b1;
        rand_inputs();
        cyc(blank(), "start");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] op;
        do_reset();

        run_instr(OP_ADD,   0, 1'b0, 1'b0, 1'b0);
        run_instr(OP_SUB,   0, 1'b0, 1'b0, 1'b0);
        run_instr(OP_INPUT, 4, 1'b0, 1'b0, 1'b0);
        run_instr(OP_JZ,    0, 1'b1, 1'b0, 1'b0);
        run_instr(OP_JZ,    0, 1'b0, 1'b1, 1'b0);
        run_instr(OP_JPOS,  0, 1'b0, 1'b1, 1'b0);
        run_instr(OP_JPOS,  0, 1'b1, 1'b0, 1'b0);
        run_instr(OP_LOAD,  0, 1'b0, 1'b0, 1'b0);
        run_instr(OP_STORE, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(6, 0));
            run_instr(op, $urandom_range(3, 0), 1'($urandom), 1'($urandom), 1'b0);
        end
        run_instr(OP_HALT, 0, 1'b0, 1'b0, 1'b0);

        do_reset();
        run_instr(OP_STORE, 0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        clear = 1'b1;
        rand_inputs();
        cyc(blank(), "start_after_abort");

        for (int i = 0; i < 9; i++) begin
            op = 3'($urandom_range(6, 0));
            run_instr(op, $urandom_range(2, 0), 1'($urandom), 1'($urandom), 1'b0);
        end
        rand_inputs();
        @(negedge clk);
        n_vec++;
        if (instr_count !== CNT_W'(1)) begin
            n_bad++;
            $display("FAIL count_wrap: got %0d expected 1", instr_count);
        end

        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
